// File: rtl/alu_ops_pkg.sv
// alu_ops_pkg: ALU op codes, MIPS opcode/funct constants and the decoded-command record shared by issue and EX stages
package alu_ops_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_MUL  = 5'b00010;
    localparam logic [4:0] ALU_SLT  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_NOR  = 5'b00110;
    localparam logic [4:0] ALU_XOR  = 5'b00111;
    localparam logic [4:0] ALU_SLL  = 5'b01000;
    localparam logic [4:0] ALU_SRL  = 5'b01001;
    localparam logic [4:0] ALU_SLLV = 5'b01010;
    localparam logic [4:0] ALU_SRLV = 5'b01011;
    localparam logic [4:0] ALU_SRA  = 5'b01100;
    localparam logic [4:0] ALU_SRAV = 5'b01101;
    localparam logic [4:0] ALU_SLTU = 5'b01111;
    localparam logic [4:0] ALU_MOVN = 5'b10000;
    localparam logic [4:0] ALU_MOVZ = 5'b10001;
    localparam logic [4:0] ALU_MULU = 5'b10010;
    localparam logic [4:0] ALU_LUI  = 5'b10101;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_SPECIAL3 = 6'h1F;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_MOVN  = 6'h0B;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;
    localparam logic [5:0] FN_MUL   = 6'h02;
    localparam logic [5:0] FN_BSHFL = 6'h20;

    // shamt selectors of the bshfl group; reused as the ADD Shift code for SEB/SEH
    localparam logic [4:0] SEB_SHAMT = 5'd16;
    localparam logic [4:0] SEH_SHAMT = 5'd24;

    typedef struct packed {
        logic [4:0] alu_control;
        logic [4:0] shift;
        logic       rotate;
        logic       alu_src_imm;
        logic       imm_zero_ext;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_op_issue_if.sv
// alu_op_issue_if: ID->EX issue handshake and decoded ALU command bundle
interface alu_op_issue_if #(parameter int CNT_W = 16);

    logic [31:0]      instruction;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic [4:0]       alu_control;
    logic [4:0]       shift;
    logic             rotate;
    logic             alu_src_imm;
    logic             imm_zero_ext;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    modport master (
        output instruction, in_valid, flush, out_ready,
        input  in_ready, out_valid, alu_control, shift, rotate, alu_src_imm, imm_zero_ext, illegal, illegal_count
    );

    modport slave (
        input  instruction, in_valid, flush, out_ready,
        output in_ready, out_valid, alu_control, shift, rotate, alu_src_imm, imm_zero_ext, illegal, illegal_count
    );

endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational MIPS instruction -> ALU command fields and illegal flag
// ALU_ROTATE_EN enables ROTR/ROTRV decode; otherwise those encodings are illegal
module alu_op_decode
    import alu_ops_pkg::*;
(
    input  logic [31:0] instruction,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] sa;
    dec_t       r;
    logic       bad;

    assign op = instruction[31:26];
    assign fn = instruction[5:0];
    assign sa = instruction[10:6];

    always_comb begin
        r   = '0;
        bad = 1'b0;
        case (op)
            OP_SPECIAL: case (fn)
                FN_ADD, FN_ADDU, FN_JR, FN_JALR: r.alu_control = ALU_ADD;
                FN_SUB, FN_SUBU: r.alu_control = ALU_SUB;
                FN_AND:   r.alu_control = ALU_AND;
                FN_OR:    r.alu_control = ALU_OR;
                FN_XOR:   r.alu_control = ALU_XOR;
                FN_NOR:   r.alu_control = ALU_NOR;
                FN_SLT:   r.alu_control = ALU_SLT;
                FN_SLTU:  r.alu_control = ALU_SLTU;
                FN_SLLV:  r.alu_control = ALU_SLLV;
                FN_SRAV:  r.alu_control = ALU_SRAV;
                FN_MOVZ:  r.alu_control = ALU_MOVZ;
                FN_MOVN:  r.alu_control = ALU_MOVN;
                FN_MULTU: r.alu_control = ALU_MULU;
                FN_SLL: begin
                    r.alu_control = ALU_SLL;
                    r.shift       = sa;
                end
                FN_SRA: begin
                    r.alu_control = ALU_SRA;
                    r.shift       = sa;
                end
                FN_SRL: begin
                    r.alu_control = ALU_SRL;
                    r.shift       = sa;
`ifdef ALU_ROTATE_EN
                    r.rotate      = instruction[21];
`else
                    bad           = instruction[21];
`endif
                end
                FN_SRLV: begin
                    r.alu_control = ALU_SRLV;
`ifdef ALU_ROTATE_EN
                    r.shift       = {4'b0, instruction[6]};
`else
                    bad           = instruction[6];
`endif
                end
                default: bad = 1'b1;
            endcase
            OP_SPECIAL2: begin
                r.alu_control = ALU_MUL;
                bad           = fn != FN_MUL;
            end
            OP_SPECIAL3: begin
                r.alu_control = ALU_ADD;
                r.shift       = sa;
                bad           = fn != FN_BSHFL || (sa != SEB_SHAMT && sa != SEH_SHAMT);
            end
            OP_ADDI, OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin
                r.alu_control = ALU_ADD;
                r.alu_src_imm = 1'b1;
            end
            OP_SLTI: begin
                r.alu_control = ALU_SLT;
                r.alu_src_imm = 1'b1;
            end
            OP_SLTIU: begin
                r.alu_control = ALU_SLTU;
                r.alu_src_imm = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                r.alu_control  = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_XOR;
                r.alu_src_imm  = 1'b1;
                r.imm_zero_ext = 1'b1;
            end
            OP_LUI: begin
                r.alu_control = ALU_LUI;
                r.alu_src_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: r.alu_control = ALU_SUB;
            OP_J, OP_JAL:   r.alu_control = ALU_ADD;
            default: bad = 1'b1;
        endcase
        // an illegal entry carries no command, only the flag
        dec         = bad ? '0 : r;
        dec.illegal = bad;
    end

endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: ID->EX issue register holding the decoded ALU command with valid/ready flow control and illegal counter
// ALU_ROTATE_EN (see alu_op_decode) selects whether ROTR/ROTRV are legal
module alu_op_issue
    import alu_ops_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    alu_op_issue_if.slave bus
);

    dec_t             d;
    dec_t             q;
    logic             valid_q;
    logic             in_ready;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    alu_op_decode u_decode (
        .instruction(bus.instruction),
        .dec        (d)
    );

    assign in_ready = !bus.flush && (!valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            q       <= '0;
            cnt     <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            q       <= d;
            if (d.illegal && !(&cnt)) cnt <= cnt + CNT_W'(1);
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.alu_control   = q.alu_control;
    assign bus.shift         = q.shift;
    assign bus.rotate        = q.rotate;
    assign bus.alu_src_imm   = q.alu_src_imm;
    assign bus.imm_zero_ext  = q.imm_zero_ext;
    assign bus.illegal       = q.illegal;
    assign bus.illegal_count = cnt;

endmodule
